// File: rtl/write_back_unit_if.sv
// Write-back stage bus: MEM-stage handshake, load data path and register-file write port.
interface write_back_unit_if #(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_REG_ADDR = 5,
    parameter int unsigned NB_WB       = 8
) ();
    logic                   i_valid;
    logic                   o_ready;
    logic [NB_WB-1:0]       i_wb;
    logic [2:0]             i_ld_ctrl;
    logic [1:0]             i_byte_off;
    logic [NB_REG-1:0]      i_reg_wb;
    logic [NB_REG-1:0]      i_pc;
    logic [NB_REG-1:0]      i_mem_data;
    logic                   i_mem_ready;
    logic [NB_REG-1:0]      o_wb_data;
    logic [NB_REG_ADDR-1:0] o_reg_dest;
    logic                   o_reg_we;
    logic                   o_timeout;
    logic                   o_misalign;

    // Upstream side: MEM stage and data memory
    modport master (
        output i_valid, i_wb, i_ld_ctrl, i_byte_off, i_reg_wb, i_pc, i_mem_data, i_mem_ready,
        input  o_ready, o_wb_data, o_reg_dest, o_reg_we, o_timeout, o_misalign
    );

    // Write-back unit side
    modport slave (
        input  i_valid, i_wb, i_ld_ctrl, i_byte_off, i_reg_wb, i_pc, i_mem_data, i_mem_ready,
        output o_ready, o_wb_data, o_reg_dest, o_reg_we, o_timeout, o_misalign
    );
endinterface

// File: rtl/write_back_unit.sv
// Registered write-back stage: selects ALU/link/load data, extends loads, waits for memory.
module write_back_unit #(
    parameter int unsigned NB_REG         = 32,
    parameter int unsigned NB_REG_ADDR    = 5,
    parameter int unsigned NB_WB          = 8,
    parameter int unsigned PC_LINK_OFFSET = 8,
    parameter int unsigned MEM_TIMEOUT    = 16,
    parameter int unsigned NB_TO_CNT      = 5
) (
    input logic               i_clock,
    input logic               i_reset,
    write_back_unit_if.slave  bus
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StWaitMem = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [NB_TO_CNT-1:0]   to_cnt_q, to_cnt_d;
    logic [NB_REG_ADDR-1:0] dest_q, dest_d;
    logic                   we_q, we_d;
    logic [2:0]             ld_ctrl_q, ld_ctrl_d;
    logic [1:0]             off_q, off_d;

    logic [NB_REG-1:0]      wb_data_q, wb_data_d;
    logic [NB_REG_ADDR-1:0] reg_dest_q, reg_dest_d;
    logic                   reg_we_q, reg_we_d;
    logic                   timeout_q, timeout_d;
    logic                   misalign_q, misalign_d;

    logic [1:0]             in_sel;
    logic                   in_we;
    logic [NB_REG_ADDR-1:0] in_dest;
    logic                   in_misalign;
    logic [NB_REG-1:0]      link_data;
    logic [2:0]             ext_ctrl;
    logic [1:0]             ext_off;
    logic [NB_REG-1:0]      load_data;

    // Lane-select and sign/zero-extend a raw little-endian memory word
    function automatic logic [NB_REG-1:0] extend_load(input logic [NB_REG-1:0] raw,
                                                      input logic [2:0]        ctrl,
                                                      input logic [1:0]        off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic        sign;
        lane_b = raw[{off, 3'b000} +: 8];
        lane_h = off[1] ? raw[31:16] : raw[15:0];
        sign   = 1'b0;
        case (ctrl[1:0])
            2'b00: begin
                sign        = ~ctrl[2] & lane_b[7];
                extend_load = {{(NB_REG - 8){sign}}, lane_b};
            end
            2'b01: begin
                sign        = ~ctrl[2] & lane_h[15];
                extend_load = {{(NB_REG - 16){sign}}, lane_h};
            end
            // Word, and the reserved size treated as word
            default: extend_load = raw;
        endcase
    endfunction

    assign in_sel    = bus.i_wb[1:0];
    assign in_we     = bus.i_wb[2];
    assign in_dest   = bus.i_wb[3 +: NB_REG_ADDR];
    assign link_data = bus.i_pc + NB_REG'(PC_LINK_OFFSET);

    // Halfword on an odd byte, or word off a word boundary
    assign in_misalign = ((bus.i_ld_ctrl[1:0] == 2'b01) && bus.i_byte_off[0]) ||
                         (bus.i_ld_ctrl[1] && (bus.i_byte_off != 2'b00));

    // While waiting, extension uses the captured load attributes, not the live inputs
    assign ext_ctrl  = (state_q == StWaitMem) ? ld_ctrl_q : bus.i_ld_ctrl;
    assign ext_off   = (state_q == StWaitMem) ? off_q : bus.i_byte_off;
    assign load_data = extend_load(bus.i_mem_data, ext_ctrl, ext_off);

    assign bus.o_ready    = (state_q == StIdle);
    assign bus.o_wb_data  = wb_data_q;
    assign bus.o_reg_dest = reg_dest_q;
    assign bus.o_reg_we   = reg_we_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_misalign = misalign_q;

    // Next-state: accept, memory wait with timeout, and output register update
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        dest_d     = dest_q;
        we_d       = we_q;
        ld_ctrl_d  = ld_ctrl_q;
        off_d      = off_q;
        wb_data_d  = wb_data_q;
        reg_dest_d = reg_dest_q;
        reg_we_d   = 1'b0;
        timeout_d  = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    if (in_sel == 2'b00) begin
                        if (in_misalign) begin
                            misalign_d = 1'b1;
                        end else if (bus.i_mem_ready) begin
                            wb_data_d  = load_data;
                            reg_dest_d = in_dest;
                            reg_we_d   = in_we && (in_dest != '0);
                        end else begin
                            state_d   = StWaitMem;
                            to_cnt_d  = '0;
                            dest_d    = in_dest;
                            we_d      = in_we;
                            ld_ctrl_d = bus.i_ld_ctrl;
                            off_d     = bus.i_byte_off;
                        end
                    end else begin
                        wb_data_d  = in_sel[0] ? link_data : bus.i_reg_wb;
                        reg_dest_d = in_dest;
                        reg_we_d   = in_we && (in_dest != '0);
                    end
                end
            end
            StWaitMem: begin
                // Memory arriving on the final cycle beats the timeout
                if (bus.i_mem_ready) begin
                    state_d    = StIdle;
                    wb_data_d  = load_data;
                    reg_dest_d = dest_q;
                    reg_we_d   = we_q && (dest_q != '0);
                end else if (to_cnt_q == NB_TO_CNT'(MEM_TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + NB_TO_CNT'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, captured load attributes and output register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            to_cnt_q   <= '0;
            dest_q     <= '0;
            we_q       <= 1'b0;
            ld_ctrl_q  <= '0;
            off_q      <= '0;
            wb_data_q  <= '0;
            reg_dest_q <= '0;
            reg_we_q   <= 1'b0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            dest_q     <= dest_d;
            we_q       <= we_d;
            ld_ctrl_q  <= ld_ctrl_d;
            off_q      <= off_d;
            wb_data_q  <= wb_data_d;
            reg_dest_q <= reg_dest_d;
            reg_we_q   <= reg_we_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: driver pushes expected events, monitor pops and compares.
module tb_write_back_unit;

    localparam int unsigned MEM_TIMEOUT    = 16;
    localparam int unsigned PC_LINK_OFFSET = 8;
    localparam int          KIND_COMMIT    = 0;
    localparam int          KIND_TIMEOUT   = 1;
    localparam int          KIND_MISALIGN  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
        logic [4:0]  dest;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    write_back_unit_if bus ();

    write_back_unit #(
        .NB_REG         (32),
        .NB_REG_ADDR    (5),
        .NB_WB          (8),
        .PC_LINK_OFFSET (PC_LINK_OFFSET),
        .MEM_TIMEOUT    (MEM_TIMEOUT),
        .NB_TO_CNT      (5)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference load extension: shift the addressed lane down, then widen
    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] ctrl,
                                              input logic [1:0] off);
        logic [31:0] v;
        if (ctrl[1:0] == 2'b00) begin
            v = (w >> (8 * int'(off))) & 32'hFF;
            if (!ctrl[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ctrl[1:0] == 2'b01) begin
            v = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
            if (!ctrl[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        if (ctrl[1:0] == 2'b01) return off[0];
        if (ctrl[1]) return off != 2'b00;
        return 1'b0;
    endfunction

    // Drive one instruction from a negedge; delay = cycles until memory is ready
    // (0 = same cycle, > MEM_TIMEOUT = never). Returns at the negedge after the result.
    task automatic issue(input logic [4:0] dest, input logic we, input logic [1:0] sel,
                         input logic [2:0] ctrl, input logic [1:0] off, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] mem, input int delay);
        int  c0;
        int  k;
        bit  is_load;
        bit  mis;
        bit  waits;
        bit  done;
        ev_t e;
        check("ready_before_issue", 32'(bus.o_ready), 32'd1);
        c0      = cyc;
        is_load = (sel == 2'b00);
        mis     = is_load && model_misaligned(ctrl, off);
        waits   = is_load && !mis && (delay != 0);

        bus.i_valid     = 1'b1;
        bus.i_wb        = {dest, we, sel};
        bus.i_ld_ctrl   = ctrl;
        bus.i_byte_off  = off;
        bus.i_reg_wb    = alu;
        bus.i_pc        = pc;
        bus.i_mem_ready = is_load ? (delay == 0) : 1'($urandom);
        bus.i_mem_data  = (is_load && delay == 0) ? mem : $urandom;

        e.data = '0;
        e.dest = dest;
        e.kind = KIND_COMMIT;
        if (!is_load) begin
            e.data = sel[0] ? pc + PC_LINK_OFFSET : alu;
            e.cyc  = c0 + 1;
        end else if (mis) begin
            e.kind = KIND_MISALIGN;
            e.cyc  = c0 + 1;
        end else if (delay <= int'(MEM_TIMEOUT)) begin
            e.data = model_ext(mem, ctrl, off);
            e.cyc  = c0 + 1 + delay;
        end else begin
            e.kind = KIND_TIMEOUT;
            e.cyc  = c0 + 1 + int'(MEM_TIMEOUT);
        end
        if (e.kind != KIND_COMMIT || (we && dest != 5'd0)) exp_q.push_back(e);

        @(posedge clk);
        if (waits) begin
            k    = 1;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                check("ready_low_in_wait", 32'(bus.o_ready), 32'd0);
                // Everything but the memory response is junk while waiting
                bus.i_valid     = 1'($urandom);
                bus.i_wb        = 8'($urandom);
                bus.i_ld_ctrl   = 3'($urandom);
                bus.i_byte_off  = 2'($urandom);
                bus.i_reg_wb    = $urandom;
                bus.i_pc        = $urandom;
                bus.i_mem_ready = (k == delay);
                bus.i_mem_data  = (k == delay) ? mem : $urandom;
                @(posedge clk);
                done = (k == delay) || (k == int'(MEM_TIMEOUT));
                k++;
            end
        end
        @(negedge clk);
        bus.i_valid     = 1'b0;
        bus.i_mem_ready = 1'b0;
    endtask

    // Monitor: every visible event must match the oldest expected one, including its cycle
    initial begin
        ev_t         e;
        logic [1:0]  act_kind;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (bus.o_reg_we || bus.o_timeout || bus.o_misalign)) begin
                check("event_onehot",
                      32'(bus.o_reg_we) + 32'(bus.o_timeout) + 32'(bus.o_misalign), 32'd1);
                act_kind = bus.o_misalign ? 2'd2 : (bus.o_timeout ? 2'd1 : 2'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", 32'(act_kind), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(act_kind), 32'(e.kind));
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.kind == KIND_COMMIT) begin
                        check("commit_data", bus.o_wb_data, e.data);
                        check("commit_dest", 32'(bus.o_reg_dest), 32'(e.dest));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sel;
        logic [4:0]  dest;
        logic        we;
        logic [2:0]  ctrl;
        logic [1:0]  off;
        int          r;
        int          delay;

        bus.i_valid     = 1'b0;
        bus.i_wb        = '0;
        bus.i_ld_ctrl   = '0;
        bus.i_byte_off  = '0;
        bus.i_reg_wb    = '0;
        bus.i_pc        = '0;
        bus.i_mem_data  = '0;
        bus.i_mem_ready = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("reset_ready", 32'(bus.o_ready), 32'd1);
        check("reset_wb_data", bus.o_wb_data, 32'd0);
        check("reset_reg_dest", 32'(bus.o_reg_dest), 32'd0);
        check("reset_reg_we", 32'(bus.o_reg_we), 32'd0);
        check("reset_timeout", 32'(bus.o_timeout), 32'd0);
        check("reset_misalign", 32'(bus.o_misalign), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back ALU results
        issue(5'd3, 1'b1, 2'b10, 3'b011, 2'd0, 32'h11, 32'h0, 32'h0, 0);
        issue(5'd4, 1'b1, 2'b10, 3'b011, 2'd0, 32'h22, 32'h0, 32'h0, 0);
        issue(5'd5, 1'b1, 2'b10, 3'b011, 2'd0, 32'h33, 32'h0, 32'h0, 0);
        check("b2b_last_data", bus.o_wb_data, 32'h33);

        // Link writes, then a link to r0 that must not write but still updates data/dest
        issue(5'd31, 1'b1, 2'b01, 3'b011, 2'd0, 32'h0, 32'h0040_0010, 32'h0, 0);
        check("link_data", bus.o_wb_data, 32'h0040_0018);
        issue(5'd0, 1'b1, 2'b01, 3'b011, 2'd0, 32'h0, 32'h0040_0020, 32'h0, 0);
        check("link_r0_we", 32'(bus.o_reg_we), 32'd0);
        check("link_r0_data", bus.o_wb_data, 32'h0040_0028);
        check("link_r0_dest", 32'(bus.o_reg_dest), 32'd0);

        // Byte/half extension from one memory word
        issue(5'd6, 1'b1, 2'b00, 3'b000, 2'd1, 32'h0, 32'h0, 32'h80F1_7F02, 0);
        check("lb_off1", bus.o_wb_data, 32'h0000_007F);
        issue(5'd6, 1'b1, 2'b00, 3'b000, 2'd2, 32'h0, 32'h0, 32'h80F1_7F02, 0);
        check("lb_off2", bus.o_wb_data, 32'hFFFF_FFF1);
        issue(5'd6, 1'b1, 2'b00, 3'b100, 2'd3, 32'h0, 32'h0, 32'h80F1_7F02, 0);
        check("lbu_off3", bus.o_wb_data, 32'h0000_0080);
        issue(5'd6, 1'b1, 2'b00, 3'b001, 2'd2, 32'h0, 32'h0, 32'h80F1_7F02, 0);
        check("lh_off2", bus.o_wb_data, 32'hFFFF_80F1);

        // Delayed memory, timeout, and ready on the final wait cycle
        issue(5'd7, 1'b1, 2'b00, 3'b011, 2'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 4);
        check("delayed_data", bus.o_wb_data, 32'hCAFE_F00D);
        issue(5'd8, 1'b1, 2'b00, 3'b011, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 99);
        check("timeout_pulse", 32'(bus.o_timeout), 32'd1);
        check("timeout_no_we", 32'(bus.o_reg_we), 32'd0);
        issue(5'd9, 1'b1, 2'b00, 3'b011, 2'd0, 32'h0, 32'h0, 32'h0BAD_BEEF, int'(MEM_TIMEOUT));
        check("last_cycle_no_timeout", 32'(bus.o_timeout), 32'd0);
        check("last_cycle_we", 32'(bus.o_reg_we), 32'd1);

        // Misaligned word load, then a normal ALU op
        issue(5'd10, 1'b1, 2'b00, 3'b011, 2'd2, 32'h0, 32'h0, 32'h5555_AAAA, 0);
        check("misalign_pulse", 32'(bus.o_misalign), 32'd1);
        check("misalign_no_we", 32'(bus.o_reg_we), 32'd0);
        check("misalign_ready", 32'(bus.o_ready), 32'd1);
        issue(5'd11, 1'b1, 2'b10, 3'b000, 2'd0, 32'hA5A5_0001, 32'h0, 32'h0, 0);
        check("after_misalign_data", bus.o_wb_data, 32'hA5A5_0001);

        // Reset in the middle of a memory wait
        bus.i_valid     = 1'b1;
        bus.i_wb        = {5'd12, 1'b1, 2'b00};
        bus.i_ld_ctrl   = 3'b011;
        bus.i_byte_off  = 2'd0;
        bus.i_mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_before_reset", 32'(bus.o_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midwait_reset_ready", 32'(bus.o_ready), 32'd1);
        check("midwait_reset_data", bus.o_wb_data, 32'd0);
        check("midwait_reset_dest", 32'(bus.o_reg_dest), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(5'd13, 1'b1, 2'b00, 3'b101, 2'd2, 32'h0, 32'h0, 32'h8001_7FFF, 2);
        check("post_reset_load", bus.o_wb_data, 32'h0000_8001);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel   = 2'($urandom);
            dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            we    = ($urandom_range(0, 5) != 0);
            ctrl  = 3'($urandom);
            off   = 2'($urandom);
            r     = int'($urandom_range(0, 9));
            delay = (r < 6) ? 0 : (r < 9) ? int'($urandom_range(1, MEM_TIMEOUT))
                                          : int'(MEM_TIMEOUT) + 1;
            issue(dest, we, sel, ctrl, off, $urandom, $urandom, $urandom, delay);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
